// File: rtl/common_enums.sv
// rtl/common_enums.sv - shared VGA timing constants, counter widths and screen state type
package common_enums;

    localparam int CNT_W = 10;
    localparam int FC_W  = 8;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Idle value of the {hs, vs, blank_n} bundle: both syncs released, output blanked.
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    typedef enum logic [1:0] {
        SCR_ACTIVE,
        SCR_H_BLANK,
        SCR_V_BLANK
    } screen_state_t;

    // Total period of one axis: visible region plus front porch, sync and back porch.
    function automatic int total_of(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sig_delay.sv
// rtl/sig_delay.sv - fixed-depth register chain with a parameterised reset value
module sig_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Zero depth is a pure wire; clock and reset are not needed.
            logic unused_bypass;
            assign unused_bypass = clk_i ^ rst_i;
            assign data_o        = data_i;
        end else begin : g_chain
            logic [WIDTH-1:0] stage_q [DEPTH];

            // Shift the input through DEPTH stages; every stage holds the reset value while reset is high.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q[0] <= data_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign data_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync/blank decode and frame counter
module vga_timing_gen
    import common_enums::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF, // visible pixels per line
    parameter int H_FP       = H_FP_DEF,     // horizontal front porch
    parameter int H_SYNC     = H_SYNC_DEF,   // horizontal sync width
    parameter int H_BP       = H_BP_DEF,     // horizontal back porch
    parameter int V_ACTIVE   = V_ACTIVE_DEF, // visible lines
    parameter int V_FP       = V_FP_DEF,     // vertical front porch
    parameter int V_SYNC     = V_SYNC_DEF,   // vertical sync width
    parameter int V_BP       = V_BP_DEF,     // vertical back porch
    parameter int PIPE_DELAY = 1             // sync/blank delay (0..4), matches pixel ROM latency
) (
    input  logic             vga_clk,     // pixel clock, the only clock
    input  logic             reset,       // asynchronous, active-high
    output logic [CNT_W-1:0] hcount,      // current pixel column
    output logic [CNT_W-1:0] vcount,      // current line
    output logic             active,      // undelayed visible-region flag
    output logic             line_start,  // undelayed, high while hcount==0
    output logic             frame_start, // undelayed, high while hcount==0 and vcount==0
    output logic             vga_hs,      // horizontal sync, active-low, delayed
    output logic             vga_vs,      // vertical sync, active-low, delayed
    output logic             vga_blank_n, // high on visible pixels, delayed
    output logic             vga_sync_n,  // sync-on-green unused, held low
    output logic [FC_W-1:0]  frame_count  // completed frames, wraps at 255
);

    localparam int H_TOTAL = total_of(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total_of(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic [FC_W-1:0]  frame_count_q, frame_count_d;
    logic             h_wrap, v_wrap;
    logic             hs_raw, vs_raw;
    logic [2:0]       sync_dly;

    // Next-state raster position: hcount free-runs, vcount steps on the line wrap, frames count on the frame wrap.
    always_comb begin
        h_wrap        = (hcount_q == H_LAST);
        v_wrap        = (vcount_q == V_LAST);
        hcount_d      = h_wrap ? '0 : hcount_q + 1'b1;
        vcount_d      = vcount_q;
        frame_count_d = frame_count_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
            if (v_wrap) begin
                frame_count_d = frame_count_q + 1'b1;
            end
        end
    end

    // Counter registers; reset clears them at once so a mid-frame reset aborts the current line.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_count_q <= '0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Undelayed decodes of the current position; these feed both the screen generator and the sync pipe.
    always_comb begin
        active      = (hcount_q < H_ACT) && (vcount_q < V_ACT);
        line_start  = (hcount_q == '0);
        frame_start = (hcount_q == '0) && (vcount_q == '0);
        hs_raw      = !((hcount_q >= HS_START) && (hcount_q < HS_END));
        vs_raw      = !((vcount_q >= VS_START) && (vcount_q < VS_END));
    end

    // Sync and blank are delayed to line up with pixel data coming out of the ROM.
    sig_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk_i  (vga_clk),
        .rst_i  (reset),
        .data_i ({hs_raw, vs_raw, active}),
        .data_o (sync_dly)
    );

    assign {vga_hs, vga_vs, vga_blank_n} = sync_dly;
    assign vga_sync_n  = 1'b0;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (full-size and reduced rasters)
module tb_vga_timing_gen;

    localparam int A_HT    = 800;
    localparam int A_VT    = 525;
    localparam int A_FRAME = A_HT * A_VT;
    localparam int B_HT    = 15;
    localparam int B_VT    = 8;
    localparam int B_FRAME = B_HT * B_VT;
    localparam logic [2:0] IDLE = 3'b110;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [9:0] a_hcount, a_vcount, b_hcount, b_vcount, c_hcount, c_vcount;
    logic [7:0] a_frame_count, b_frame_count, c_frame_count;
    logic a_active, a_line_start, a_frame_start, a_hs, a_vs, a_blank_n, a_sync_n;
    logic b_active, b_line_start, b_frame_start, b_hs, b_vs, b_blank_n, b_sync_n;
    logic c_active, c_line_start, c_frame_start, c_hs, c_vs, c_blank_n, c_sync_n;

    always #20 clk = ~clk;

    vga_timing_gen dut_a (
        .vga_clk(clk), .reset(rst), .hcount(a_hcount), .vcount(a_vcount),
        .active(a_active), .line_start(a_line_start), .frame_start(a_frame_start),
        .vga_hs(a_hs), .vga_vs(a_vs), .vga_blank_n(a_blank_n), .vga_sync_n(a_sync_n),
        .frame_count(a_frame_count)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(1)
    ) dut_b (
        .vga_clk(clk), .reset(rst), .hcount(b_hcount), .vcount(b_vcount),
        .active(b_active), .line_start(b_line_start), .frame_start(b_frame_start),
        .vga_hs(b_hs), .vga_vs(b_vs), .vga_blank_n(b_blank_n), .vga_sync_n(b_sync_n),
        .frame_count(b_frame_count)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(0)
    ) dut_c (
        .vga_clk(clk), .reset(rst), .hcount(c_hcount), .vcount(c_vcount),
        .active(c_active), .line_start(c_line_start), .frame_start(c_frame_start),
        .vga_hs(c_hs), .vga_vs(c_vs), .vga_blank_n(c_blank_n), .vga_sync_n(c_sync_n),
        .frame_count(c_frame_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [2:0] sb_a[$];
    logic [2:0] sb_b[$];
    logic [2:0] exp_a = IDLE;
    logic [2:0] exp_b = IDLE;

    function automatic logic [2:0] und(int h, int v, int ha, int hfp, int hsw, int va, int vfp, int vsw);
        logic hs_n, vs_n, bl;
        hs_n = !((h >= ha + hfp) && (h < ha + hfp + hsw));
        vs_n = !((v >= va + vfp) && (v < va + vfp + vsw));
        bl   = (h < ha) && (v < va);
        return {hs_n, vs_n, bl};
    endfunction

    function automatic logic [2:0] und_a(int c);
        return und(c % A_HT, (c / A_HT) % A_VT, 640, 16, 96, 480, 10, 2);
    endfunction

    function automatic logic [2:0] und_b(int c);
        return und(c % B_HT, (c / B_HT) % B_VT, 8, 2, 3, 4, 1, 2);
    endfunction

    function automatic logic [27:0] ctr_a(int c);
        return {10'(c % A_HT), 10'((c / A_HT) % A_VT), 8'((c / A_FRAME) % 256)};
    endfunction

    function automatic logic [27:0] ctr_b(int c);
        return {10'(c % B_HT), 10'((c / B_HT) % B_VT), 8'((c / B_FRAME) % 256)};
    endfunction

    function automatic logic [2:0] dec_a(int c);
        int h, v;
        h = c % A_HT;
        v = (c / A_HT) % A_VT;
        return {(h < 640) && (v < 480), h == 0, (h == 0) && (v == 0)};
    endfunction

    function automatic logic [2:0] dec_b(int c);
        int h, v;
        h = c % B_HT;
        v = (c / B_HT) % B_VT;
        return {(h < 8) && (v < 4), h == 0, (h == 0) && (v == 0)};
    endfunction

    // Push the expected undelayed bundle for the current position, clock once, pop what the pipe now shows.
    task automatic tick();
        sb_a.push_back(und_a(cyc));
        sb_b.push_back(und_b(cyc));
        @(posedge clk);
        #1;
        cyc++;
        exp_a = sb_a.pop_front();
        exp_b = sb_b.pop_front();
    endtask

    task automatic model_reset();
        cyc = 0;
        sb_a.delete();
        sb_b.delete();
        exp_a = IDLE;
        exp_b = IDLE;
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #7;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({a_hcount, a_vcount, a_frame_count} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_counters_a: got %h expected 0", {a_hcount, a_vcount, a_frame_count});
        end
        n_checks++;
        if ({a_hs, a_vs, a_blank_n, a_sync_n} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_sync_a: got %b expected 1100", {a_hs, a_vs, a_blank_n, a_sync_n});
        end
        n_checks++;
        if ({a_active, a_line_start, a_frame_start} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_decode_a: got %b expected 111", {a_active, a_line_start, a_frame_start});
        end
        n_checks++;
        if ({b_hcount, b_vcount, b_frame_count, b_hs, b_vs, b_blank_n, b_sync_n} !== {28'd0, 4'b1100}) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected %h",
                     {b_hcount, b_vcount, b_frame_count, b_hs, b_vs, b_blank_n, b_sync_n}, {28'd0, 4'b1100});
        end
        n_checks++;
        if ({c_hs, c_vs, c_sync_n} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_c_sync: got %b expected 110", {c_hs, c_vs, c_sync_n});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({a_hcount, a_vcount, a_frame_count, a_hs, a_vs, a_blank_n} !== {28'd0, 3'b110}) begin
            n_fail++;
            $display("FAIL reset_hold_edge: got %h expected %h",
                     {a_hcount, a_vcount, a_frame_count, a_hs, a_vs, a_blank_n}, {28'd0, 3'b110});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({a_line_start, a_frame_start} !== 2'b11) begin
            n_fail++;
            $display("FAIL release_starts: got %b expected 11", {a_line_start, a_frame_start});
        end
        tick();
        n_checks++;
        if ({a_hcount, a_vcount} !== {10'd1, 10'd0}) begin
            n_fail++;
            $display("FAIL first_edge_count: got h=%0d v=%0d expected h=1 v=0", a_hcount, a_vcount);
        end
        n_checks++;
        if ({a_hs, a_vs, a_blank_n} !== exp_a) begin
            n_fail++;
            $display("FAIL first_edge_pipe: got %b expected %b", {a_hs, a_vs, a_blank_n}, exp_a);
        end
    endtask

    task automatic test_first_line();
        int ls;
        ls = 0;
        do_reset();
        for (int i = 0; i < A_HT; i++) begin
            tick();
            n_checks++;
            if ({a_hcount, a_vcount, a_frame_count} !== ctr_a(cyc)) begin
                n_fail++;
                $display("FAIL line_counters cyc=%0d: got %h expected %h", cyc,
                         {a_hcount, a_vcount, a_frame_count}, ctr_a(cyc));
            end
            n_checks++;
            if ({a_hs, a_vs, a_blank_n} !== exp_a) begin
                n_fail++;
                $display("FAIL line_pipe cyc=%0d: got %b expected %b", cyc, {a_hs, a_vs, a_blank_n}, exp_a);
            end
            n_checks++;
            if ({a_active, a_line_start, a_frame_start} !== dec_a(cyc)) begin
                n_fail++;
                $display("FAIL line_decode cyc=%0d: got %b expected %b", cyc,
                         {a_active, a_line_start, a_frame_start}, dec_a(cyc));
            end
            if (a_line_start) ls++;
        end
        n_checks++;
        if (ls != 1) begin
            n_fail++;
            $display("FAIL line_start_pulses: got %0d expected 1", ls);
        end
        n_checks++;
        if ({a_hcount, a_vcount} !== {10'd0, 10'd1}) begin
            n_fail++;
            $display("FAIL line_wrap: got h=%0d v=%0d expected h=0 v=1", a_hcount, a_vcount);
        end
    endtask

    task automatic test_hsync_edges();
        int h;
        for (int i = 0; i < 760; i++) begin
            tick();
            h = cyc % A_HT;
            if (h == 640 || h == 641) begin
                n_checks++;
                if (a_blank_n !== (h == 640)) begin
                    n_fail++;
                    $display("FAIL blank_edge h=%0d: got %b expected %b", h, a_blank_n, (h == 640));
                end
            end
            if (h == 656 || h == 657 || h == 752 || h == 753) begin
                n_checks++;
                if (a_hs !== (h == 656 || h == 753)) begin
                    n_fail++;
                    $display("FAIL hs_edge h=%0d: got %b expected %b", h, a_hs, (h == 656 || h == 753));
                end
            end
            n_checks++;
            if ({a_hs, a_vs, a_blank_n} !== exp_a) begin
                n_fail++;
                $display("FAIL hs_pipe cyc=%0d: got %b expected %b", cyc, {a_hs, a_vs, a_blank_n}, exp_a);
            end
        end
    endtask

    task automatic test_vsync_frame();
        int vs_low, bl_hi, first_vs, fs_at;
        vs_low   = 0;
        bl_hi    = 0;
        first_vs = -1;
        fs_at    = -1;
        do_reset();
        for (int i = 0; i < B_FRAME; i++) begin
            tick();
            n_checks++;
            if ({b_hs, b_vs, b_blank_n} !== exp_b) begin
                n_fail++;
                $display("FAIL vs_pipe_b cyc=%0d: got %b expected %b", cyc, {b_hs, b_vs, b_blank_n}, exp_b);
            end
            n_checks++;
            if ({c_hs, c_vs, c_blank_n} !== und_b(cyc)) begin
                n_fail++;
                $display("FAIL vs_comb_c cyc=%0d: got %b expected %b", cyc, {c_hs, c_vs, c_blank_n}, und_b(cyc));
            end
            if (!b_vs) begin
                vs_low++;
                if (first_vs < 0) first_vs = cyc;
            end
            if (b_blank_n) bl_hi++;
            if (b_frame_start && fs_at < 0) fs_at = cyc;
        end
        n_checks++;
        if (vs_low != 30) begin
            n_fail++;
            $display("FAIL vs_low_cycles: got %0d expected 30", vs_low);
        end
        n_checks++;
        if (first_vs != 76) begin
            n_fail++;
            $display("FAIL vs_fall_cycle: got %0d expected 76", first_vs);
        end
        n_checks++;
        if (bl_hi != 32) begin
            n_fail++;
            $display("FAIL blank_hi_cycles: got %0d expected 32", bl_hi);
        end
        n_checks++;
        if (fs_at != B_FRAME) begin
            n_fail++;
            $display("FAIL frame_period: got %0d expected %0d", fs_at, B_FRAME);
        end
        n_checks++;
        if (b_frame_count !== 8'd1) begin
            n_fail++;
            $display("FAIL frame_count_step: got %0d expected 1", b_frame_count);
        end
    endtask

    task automatic test_frame_wrap();
        int saw255;
        saw255 = 0;
        do_reset();
        for (int i = 0; i < 256 * B_FRAME; i++) begin
            tick();
            n_checks++;
            if ({b_hcount, b_vcount, b_frame_count, b_active, b_line_start, b_frame_start, b_hs, b_vs, b_blank_n}
                !== {ctr_b(cyc), dec_b(cyc), exp_b}) begin
                n_fail++;
                $display("FAIL wrap_b cyc=%0d: got %h expected %h", cyc,
                         {b_hcount, b_vcount, b_frame_count, b_active, b_line_start, b_frame_start, b_hs, b_vs, b_blank_n},
                         {ctr_b(cyc), dec_b(cyc), exp_b});
            end
            n_checks++;
            if ({c_hcount, c_vcount, c_frame_count, c_active, c_line_start, c_frame_start, c_hs, c_vs, c_blank_n, c_sync_n}
                !== {ctr_b(cyc), dec_b(cyc), und_b(cyc), 1'b0}) begin
                n_fail++;
                $display("FAIL wrap_c cyc=%0d: got %h expected %h", cyc,
                         {c_hcount, c_vcount, c_frame_count, c_active, c_line_start, c_frame_start, c_hs, c_vs, c_blank_n, c_sync_n},
                         {ctr_b(cyc), dec_b(cyc), und_b(cyc), 1'b0});
            end
            if (b_frame_start && b_frame_count == 8'd255) saw255++;
        end
        n_checks++;
        if (saw255 != 1) begin
            n_fail++;
            $display("FAIL frame_255_seen: got %0d expected 1", saw255);
        end
        n_checks++;
        if ({b_frame_count, c_frame_count} !== 16'd0) begin
            n_fail++;
            $display("FAIL frame_count_wrap: got b=%0d c=%0d expected 0", b_frame_count, c_frame_count);
        end
    endtask

    task automatic test_midframe_reset();
        do_reset();
        repeat (A_HT + 300) tick();
        n_checks++;
        if ({a_hcount, a_vcount} !== {10'd300, 10'd1}) begin
            n_fail++;
            $display("FAIL midframe_position: got h=%0d v=%0d expected h=300 v=1", a_hcount, a_vcount);
        end
        #10;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({a_hcount, a_vcount, a_frame_count, a_hs, a_vs, a_blank_n} !== {28'd0, 3'b110}) begin
            n_fail++;
            $display("FAIL midframe_abort_a: got %h expected %h",
                     {a_hcount, a_vcount, a_frame_count, a_hs, a_vs, a_blank_n}, {28'd0, 3'b110});
        end
        n_checks++;
        if ({b_hcount, b_vcount, b_frame_count, b_hs, b_vs, b_blank_n} !== {28'd0, 3'b110}) begin
            n_fail++;
            $display("FAIL midframe_abort_b: got %h expected %h",
                     {b_hcount, b_vcount, b_frame_count, b_hs, b_vs, b_blank_n}, {28'd0, 3'b110});
        end
        #5;
        rst = 1'b0;
        model_reset();
        tick();
        n_checks++;
        if ({a_hcount, a_vcount, a_hs, a_vs, a_blank_n} !== {10'd1, 10'd0, exp_a}) begin
            n_fail++;
            $display("FAIL midframe_restart: got %h expected %h",
                     {a_hcount, a_vcount, a_hs, a_vs, a_blank_n}, {10'd1, 10'd0, exp_a});
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_hsync_edges();
        test_vsync_frame();
        test_frame_wrap();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The parameter list SHALL be one per line, name, default and meaning.
- H_ACTIVE 640: visible pixels per line.
- H_FP 16: horizontal front porch.
- H_SYNC 96: horizontal sync width.
- H_BP 48: horizontal back porch.
- V_ACTIVE 480: visible lines.
- V_FP 10: vertical front porch.
- V_SYNC 2: vertical sync width.
- V_BP 33: vertical back porch.
- PIPE_DELAY 1: cycles of delay on sync/blank, range 0..4, matching the downstream pixel ROM latency.
REQ-002 The port list SHALL be one per line, name, direction, width and meaning.
- vga_clk  in  1  25 MHz pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- hcount  out  10  current pixel column 0..H_TOTAL-1; feeds the screen generator.
- vcount  out  10  current line 0..V_TOTAL-1; feeds the screen generator.
- active  out  1  undelayed; hcount<H_ACTIVE and vcount<V_ACTIVE.
- line_start  out  1  undelayed; one-cycle pulse when hcount==0.
- frame_start  out  1  undelayed; one-cycle pulse when hcount==0 and vcount==0.
- vga_hs  out  1  horizontal sync, active-low, delayed PIPE_DELAY cycles.
- vga_vs  out  1  vertical sync, active-low, delayed PIPE_DELAY cycles.
- vga_blank_n  out  1  high during visible pixels, delayed PIPE_DELAY cycles.
- vga_sync_n  out  1  tied to 0; the DAC's sync-on-green is unused.
- frame_count  out  8  number of completed frames, wraps at 255.

Function
REQ-003 Derived values SHALL be H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-004 hcount SHALL increment by 1 on every vga_clk rising edge and wrap from H_TOTAL-1 to 0.
REQ-005 vcount SHALL increment only on the edge where hcount wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-006 hcount and vcount SHALL be driven directly from their registers, with no added latency.
REQ-007 The undelayed horizontal sync SHALL be 0 exactly when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (default 656..751).
REQ-008 The undelayed vertical sync SHALL be 0 exactly when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (default 490..491).
REQ-009 The undelayed blank_n SHALL equal active.
REQ-010 vga_hs, vga_vs and vga_blank_n SHALL be the undelayed values passed through a PIPE_DELAY-stage register chain.
REQ-011 With PIPE_DELAY=0, vga_hs, vga_vs and vga_blank_n SHALL be combinational from the counters.
REQ-012 active, line_start and frame_start SHALL be combinational decodes of the current counter values.
REQ-013 frame_count SHALL increment on the edge where both counters wrap to 0.
REQ-014 frame_count SHALL wrap from 255 to 0.
REQ-015 A vga_clk edge with no reset asserted SHALL always advance the counters; the block has no stall or enable input.

Reset
REQ-016 While reset=1, hcount, vcount and frame_count SHALL be 0, independent of vga_clk.
REQ-017 While reset=1, every delay stage SHALL hold the idle values hs=1, vs=1, blank_n=0.
REQ-018 While reset=1, vga_hs=1, vga_vs=1 and vga_blank_n=0.
REQ-019 On the first edge after reset deasserts, hcount SHALL become 1.
REQ-020 frame_start and line_start SHALL be 1 during and immediately after reset, because the counters are 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately, with no completion of the current line.

Structure
REQ-022 The default timing constants, H_TOTAL/V_TOTAL derivation and counter width SHALL live in the shared common_enums package, alongside screen_state_t.
REQ-023 The delay chain SHALL be one sub-module, sig_delay, parameterised by width and depth, with async active-high reset and a parameterised reset value.
REQ-024 Counters and decode logic SHALL reside in vga_timing_gen.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Reset release, then count 800 cycles -> hcount sequence 1..799,0; vcount goes 0->1 on the wrap edge; line_start pulses once.
- Run one full frame -> exactly 420000 cycles between frame_start pulses; frame_count increments by 1.
- PIPE_DELAY=1 -> vga_hs falls one cycle after hcount==656, rises one cycle after hcount==752; vga_blank_n falls one cycle after hcount==640.
- vcount 489->490 -> vga_vs=0 for exactly 1600 cycles (lines 490-491), then 1; vga_blank_n stays 0 from line 480 to 524.
- Run 256 frames -> frame_count returns to 0.
- Assert reset at hcount=300, vcount=200 without a clock edge -> outputs go to hcount=0, vcount=0, vga_hs=1, vga_vs=1, vga_blank_n=0 immediately; the frame restarts on release.
